lvds_echo_checker: RTL
======================

Name: lvds_echo_checker

Overview:
- Synthesizable, self-checking traffic generator and checker for inter-FPGA LVDS echo links.
- Replaces the fixed-length simulation-only echo bench flow; usable both in simulation and on hardware.
- Sends a PRBS word stream toward the link TX path and compares words echoed back on the RX path against a locally regenerated copy.
- Reports pass/fail, error count and timeout; sequence length, word width, outstanding-word limit and timeout are parametrised.

Parameters:
- DATA_W, 8, payload word width; legal range 1..16.
- NUM_WORDS, 1024, words sent per run; must be ≥1.
- MAX_OUTSTANDING, 16, maximum words sent but not yet echoed; must be ≥1.
- TIMEOUT_CYC, 4096, idle cycles with words outstanding before the run aborts.
- SEED, 16'hACE1, LFSR seed; a value of 0 is replaced by 16'hACE1.
- ERR_W, 16, error counter width.

Ports:
- CLK  in  1  single clock.
- RST_N  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse that begins a run; ignored unless the FSM is in IDLE, DONE or FAIL.
- tx_data  out  DATA_W  word toward the link serializer.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  serializer accepts the word; a transfer happens when tx_valid and tx_ready are both 1.
- rx_data  in  DATA_W  echoed word from the deserializer.
- rx_valid  in  1  rx_data valid; no backpressure, so the checker always accepts.
- busy  out  1  run in progress.
- done  out  1  run finished (pass or fail); held until the next start.
- pass  out  1  valid only while done=1.
- timeout  out  1  the run aborted on the idle timer.
- err_count  out  ERR_W  mismatches plus unexpected words; saturates at all-ones.
- words_sent  out  16  accepted TX transfers in the current run.
- words_rcvd  out  16  RX words in the current run, including unexpected words.

Behaviour:
- Reset values: all outputs 0. FSM in IDLE. Both LFSRs loaded with the effective SEED. Counters cleared.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Shift left; new bit 0 = XOR of bits 15,13,12,10.
  - tx_data = tx_lfsr[DATA_W-1:0].
  - tx_lfsr advances exactly once per TX transfer.
- Checker: rx_lfsr follows the identical sequence and advances once per expected RX word.
  - Mismatch when rx_data != rx_lfsr[DATA_W-1:0].
- FSM states: IDLE, RUN, DONE, FAIL.
- start in IDLE, DONE or FAIL → next cycle enters RUN.
  - Both LFSRs reload with the seed.
  - All counters and done/pass/timeout clear.
  - busy=1.
- RUN, TX side:
  - tx_valid=1 while words_sent<NUM_WORDS and outstanding<MAX_OUTSTANDING.
  - tx_data is stable while tx_valid=1 and tx_ready=0.
  - outstanding = words_sent − expected words received.
- RUN, RX side:
  - rx_valid with outstanding>0: compare, advance rx_lfsr, increment words_rcvd; err_count++ on mismatch.
  - rx_valid with outstanding=0: unexpected word. err_count++ and words_rcvd++; no compare, rx_lfsr does not advance.
- Simultaneous TX transfer and expected RX in the same cycle: outstanding is unchanged.
  - The RX word counts as expected only if outstanding>0 before that cycle.
- Idle timer:
  - Counts cycles in RUN with outstanding>0 and no rx_valid.
  - Clears on any rx_valid, and whenever outstanding=0.
  - Reaching TIMEOUT_CYC → FAIL with timeout=1.
- RUN → DONE when words_sent=NUM_WORDS and outstanding=0 (checked after the cycle's updates).
  - pass = (err_count==0).
- FAIL sets done=1, pass=0. busy=0 in DONE and FAIL.
- In DONE/FAIL:
  - Late rx_valid increments words_rcvd and err_count but does not change pass.
  - tx_valid=0.
- start while in RUN is ignored.
- Asynchronous RST_N assertion mid-run immediately returns everything to reset values. tx_valid drops without a handshake.
- err_count saturates and does not wrap. words_sent/words_rcvd wrap modulo 2^16; NUM_WORDS must be ≤65535.
- Latency: TX stream starts the cycle after start is sampled. The compare result is reflected in err_count one cycle after rx_valid.

Optional Feature:
- Macro ECHO_CHECK_ERR_INJECT_EN.
- Defined: adds input inject_err (1 bit). A pulse during RUN arms a flag. The next TX transfer XORs bit 0 of tx_data with 1, then the flag clears. The LFSR is unaffected, so the echoed word produces exactly one mismatch. A pulse in IDLE, DONE or FAIL is ignored.
- Undefined: the port is absent and tx_data is always the pure LFSR value.

Test Plan:
- Ideal loopback (rx = tx delayed 3 cycles, tx_ready=1), NUM_WORDS=1024 → done=1, pass=1, err_count=0, words_sent=words_rcvd=1024.
- tx_ready toggled 1/0 every cycle, loopback delay 40 cycles, MAX_OUTSTANDING=16 → tx_valid drops when 16 are outstanding; tx_data stable across stalls; pass=1.
- Loopback flips bit 2 of words 5 and 700 → pass=0, err_count=2, timeout=0.
- Loopback drops word 10, TIMEOUT_CYC=100 → FAIL, timeout=1, pass=0, about 100 idle cycles after the last rx_valid.
- rx_valid pulsed in IDLE and after DONE → err_count increments, pass of the completed run unchanged. A new start clears all counters.
- RST_N low mid-run at word 300, then start → all outputs 0 during reset; the new run's first tx_data equals SEED[DATA_W-1:0] (8'hE1).
- With ECHO_CHECK_ERR_INJECT_EN defined: one inject_err pulse → err_count=1, pass=0.

Source files
------------

// File: rtl/lvds_echo_checker.sv
// lvds_echo_checker: PRBS traffic generator and echo checker for LVDS links.
// Words go out on the TX side and are compared with the echo that comes back on
// the RX side. The checker holds its own copy of the PRBS sequence to compare against.
// Optional feature macro: ECHO_CHECK_ERR_INJECT_EN adds the inject_err input.
//
// Handshake: a TX word transfers on a rising CLK edge where tx_valid and tx_ready
// are both 1. tx_valid does not depend on tx_ready. tx_data holds its value while
// tx_valid=1 and tx_ready=0. The RX side has no backpressure. Every cycle with
// rx_valid=1 is consumed.
module lvds_echo_checker #(
    parameter int          DATA_W          = 8,
    parameter int          NUM_WORDS       = 1024,
    parameter int          MAX_OUTSTANDING = 16,
    parameter int          TIMEOUT_CYC     = 4096,
    parameter logic [15:0] SEED            = 16'hACE1,
    parameter int          ERR_W           = 16
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              start,
`ifdef ECHO_CHECK_ERR_INJECT_EN
    input  logic              inject_err,
`endif
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [ERR_W-1:0]  err_count,
    output logic [15:0]       words_sent,
    output logic [15:0]       words_rcvd,
    output logic [1:0]        dbg_state
);
    localparam logic [15:0]       SEED_EFF = (SEED == 16'd0) ? 16'hACE1 : SEED;
    localparam int                OUT_W    = $clog2(MAX_OUTSTANDING + 1);
    localparam int                TMO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [15:0]       NUM_W16  = 16'(NUM_WORDS);
    localparam logic [OUT_W-1:0]  MAX_OUT  = OUT_W'(MAX_OUTSTANDING);
    localparam logic [TMO_W-1:0]  TMO_LIM  = TMO_W'(TIMEOUT_CYC);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_FAIL} state_e;

    state_e             state_q, state_d;
    logic [15:0]        tx_lfsr_q, tx_lfsr_d;
    logic [15:0]        rx_lfsr_q, rx_lfsr_d;
    logic [OUT_W-1:0]   out_q, out_d;
    logic [15:0]        sent_q, sent_d;
    logic [15:0]        rcvd_q, rcvd_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic [TMO_W-1:0]   idle_q, idle_d;
    logic               pass_q, pass_d;
    logic               tmo_q, tmo_d;
    logic               inj_q, inj_d;
    logic               tx_fire, rx_exp, err_inc, inj_pulse;

    // Fibonacci LFSR, taps 16,14,13,11: shift left, feedback into bit 0.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

`ifdef ECHO_CHECK_ERR_INJECT_EN
    assign inj_pulse = inject_err;
`else
    assign inj_pulse = 1'b0;
`endif

    // TX offer: gated by run length and the outstanding-word window.
    assign tx_valid = (state_q == S_RUN) && (sent_q < NUM_W16) && (out_q < MAX_OUT);
    assign tx_fire  = tx_valid && tx_ready;
    // An RX word is expected only if something was outstanding before this cycle.
    assign rx_exp   = (state_q == S_RUN) && rx_valid && (out_q != '0);

    // Next-state logic for the FSM, the LFSRs and all counters.
    always_comb begin
        state_d   = state_q;
        tx_lfsr_d = tx_lfsr_q;
        rx_lfsr_d = rx_lfsr_q;
        out_d     = out_q;
        sent_d    = sent_q;
        rcvd_d    = rcvd_q;
        err_d     = err_q;
        idle_d    = idle_q;
        pass_d    = pass_q;
        tmo_d     = tmo_q;
        inj_d     = inj_q;
        err_inc   = 1'b0;

        if (rx_valid) begin
            rcvd_d = rcvd_q + 16'd1;
            // Outside RUN, or with nothing outstanding, the word is unexpected.
            if (!rx_exp || (rx_data != rx_lfsr_q[DATA_W-1:0])) err_inc = 1'b1;
        end
        if (err_inc && (err_q != '1)) err_d = err_q + ERR_W'(1);

        if (state_q == S_RUN) begin
            if (tx_fire) begin
                tx_lfsr_d = lfsr_next(tx_lfsr_q);
                sent_d    = sent_q + 16'd1;
                inj_d     = 1'b0;
            end
            if (inj_pulse) inj_d = 1'b1;
            if (rx_exp) rx_lfsr_d = lfsr_next(rx_lfsr_q);
            if (tx_fire && !rx_exp)      out_d = out_q + OUT_W'(1);
            else if (!tx_fire && rx_exp) out_d = out_q - OUT_W'(1);

            if (rx_valid || (out_q == '0)) idle_d = '0;
            else                           idle_d = idle_q + TMO_W'(1);

            if (idle_d == TMO_LIM) begin
                state_d = S_FAIL;
                tmo_d   = 1'b1;
                pass_d  = 1'b0;
            end else if ((sent_d == NUM_W16) && (out_d == '0)) begin
                state_d = S_DONE;
                pass_d  = (err_d == '0);
            end
        end

        if (start && (state_q != S_RUN)) begin
            state_d   = S_RUN;
            tx_lfsr_d = SEED_EFF;
            rx_lfsr_d = SEED_EFF;
            out_d     = '0;
            sent_d    = '0;
            rcvd_d    = '0;
            err_d     = '0;
            idle_d    = '0;
            pass_d    = 1'b0;
            tmo_d     = 1'b0;
            inj_d     = 1'b0;
        end
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= S_IDLE;
            tx_lfsr_q <= SEED_EFF;
            rx_lfsr_q <= SEED_EFF;
            out_q     <= '0;
            sent_q    <= '0;
            rcvd_q    <= '0;
            err_q     <= '0;
            idle_q    <= '0;
            pass_q    <= 1'b0;
            tmo_q     <= 1'b0;
            inj_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_lfsr_q <= tx_lfsr_d;
            rx_lfsr_q <= rx_lfsr_d;
            out_q     <= out_d;
            sent_q    <= sent_d;
            rcvd_q    <= rcvd_d;
            err_q     <= err_d;
            idle_q    <= idle_d;
            pass_q    <= pass_d;
            tmo_q     <= tmo_d;
            inj_q     <= inj_d;
        end
    end

    // tx_data is driven to zero outside RUN so that every output is 0 after reset.
    assign tx_data    = (state_q == S_RUN) ? (tx_lfsr_q[DATA_W-1:0] ^ DATA_W'(inj_q)) : '0;
    assign busy       = (state_q == S_RUN);
    assign done       = (state_q == S_DONE) || (state_q == S_FAIL);
    assign pass       = pass_q;
    assign timeout    = tmo_q;
    assign err_count  = err_q;
    assign words_sent = sent_q;
    assign words_rcvd = rcvd_q;
    assign dbg_state  = state_q;

endmodule
